mesh_term_src_fifo: RTL and testbench
=====================================

Name: mesh_term_src_fifo

Overview:
- Per-terminal ingress buffer directly upstream of the 4x4 mesh router: one instance per mesh terminal.
- Accepts packets from the test driver, buffers them in a first-word-fall-through FIFO, and presents them to the mesh on the pndng_i_in/data_out_i_in/popin handshake.
- Rejects packets with an illegal destination.
- Exposes occupancy, sticky overflow/underflow flags and saturating drop counters for the scoreboard and checkers.

Parameters:
- pckg_sz, 40, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination id {row[3:0], col[3:0]}.
- fifo_depth, 4, number of packet entries; power of two, at least 2.
- broadcast, 8'hFF, destination id meaning "all terminals".

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- push  input  1  driver writes din this cycle
- din  input  pckg_sz  packet from driver
- full  output  1  count == fifo_depth
- count  output  $clog2(fifo_depth)+1  current occupancy
- pndng_i_in  output  1  head packet valid toward mesh
- data_out_i_in  output  pckg_sz  head packet toward mesh
- popin  input  1  mesh consumes head this cycle
- overflow  output  1  sticky: a push was dropped because the FIFO was full
- underflow  output  1  sticky: popin arrived while empty
- drop_cnt  output  16  packets dropped because the FIFO was full (saturating)
- bad_dst_cnt  output  16  packets dropped because the destination was illegal (saturating)

Behaviour:
- Reset (sampled on the clk edge while reset=1):
  - rd_ptr, wr_ptr, count, overflow, underflow, drop_cnt and bad_dst_cnt clear to 0.
  - pndng_i_in=0, full=0, data_out_i_in=0.
  - Reset asserted mid-traffic discards all buffered packets. Push and popin are ignored in every reset cycle.
- Destination check (combinational on din): the packet is legal when
  - dest == broadcast, or
  - row in 1..4 and col in 1..4.
  Any other value is illegal.
- Write, evaluated on the clk edge with push=1:
  - Illegal destination: drop, bad_dst_cnt+1. This check takes precedence over the full check.
  - Legal, and either count < fifo_depth or a pop happens in the same cycle while full: store at wr_ptr, wr_ptr+1 modulo fifo_depth.
  - Legal and full with no simultaneous pop: drop, drop_cnt+1, overflow set to 1.
- Read:
  - pndng_i_in = (count != 0). data_out_i_in = mem[rd_ptr], which is first-word fall-through.
  - data_out_i_in is held at the last value when empty.
  - popin=1 with count>0: rd_ptr+1 modulo fifo_depth.
  - popin=1 with count==0: no state change, underflow set to 1.
- Count update:
  - +1 on an accepted write without a pop.
  - -1 on a pop without an accepted write.
  - Unchanged when both or neither happen.
- Simultaneous push and pop when empty: the packet is stored; underflow is set; count ends at 1. There is no bypass, so latency from push to pndng_i_in is 1 cycle.
- Packet ordering is preserved. Packets are never modified.
- overflow and underflow clear only on reset.
- drop_cnt and bad_dst_cnt saturate at 16'hFFFF.
- Pointers wrap with no bubble.
- Minimum spacing: the mesh may assert popin on consecutive cycles; throughput is 1 packet per cycle.

Test Plan:
- Reset then idle: after reset, count=0, pndng_i_in=0, full=0, overflow=0 and both counters are 0; they stay there for 10 idle cycles.
- Push 4 legal packets, dest 8'h23 and payloads 1..4, on consecutive cycles with no popin:
  - full=1 and count=4 one cycle after the 4th push.
  - A 5th push sets overflow=1, drop_cnt=1 and leaves count=4.
- Pop the full FIFO with popin held 4 cycles: data_out_i_in presents payloads 1, 2, 3, 4 in order. Then pndng_i_in=0, count=0, and underflow stays 0.
- Push dest 8'h05, then 8'h50, then 8'hFF:
  - The first two are dropped and bad_dst_cnt=2.
  - The broadcast packet is accepted, with pndng_i_in=1 the next cycle.
- Full FIFO with simultaneous push and popin: the new packet is accepted, count stays 4 and drop_cnt is unchanged. Separately, popin on an empty FIFO sets underflow=1 and count stays 0.
- Reset with 3 packets buffered: the next cycle gives count=0, pndng_i_in=0, and the sticky flags and counters at 0. A subsequent push/pop round-trip returns the correct payload after a pointer wrap (push 6, pop 6).

Source files
------------

// File: rtl/mesh_term_src_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mesh_term_src_fifo
// Brief    : Per-terminal ingress buffer feeding one 4x4 mesh terminal.
//            First-word-fall-through FIFO that drops packets with an illegal
//            destination, keeps sticky overflow/underflow flags and keeps
//            saturating drop counters.
// Revision : 1.0 - initial release
// ============================================================================
module mesh_term_src_fifo #(
    parameter int          PCKG_SZ    = 40,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  BROADCAST  = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [PCKG_SZ-1:0]              din,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            pndng_i_in,
    output logic [PCKG_SZ-1:0]              data_out_i_in,
    input  logic                            popin,
    output logic                            overflow,
    output logic                            underflow,
    output logic [15:0]                     drop_cnt,
    output logic [15:0]                     bad_dst_cnt
);

    localparam int                c_AW    = $clog2(FIFO_DEPTH);
    localparam int                c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0]   c_DEPTH = c_CW'(FIFO_DEPTH);
    localparam logic [15:0]       c_SAT   = 16'hFFFF;

    logic [PCKG_SZ-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_CW-1:0]    r_count;
    logic [PCKG_SZ-1:0] r_hold;
    logic               r_overflow;
    logic               r_underflow;
    logic [15:0]        r_drop_cnt;
    logic [15:0]        r_bad_dst_cnt;

    logic [7:0]         w_dst;
    logic [3:0]         w_row;
    logic [3:0]         w_col;
    logic               w_legal;
    logic               w_empty;
    logic               w_full;
    logic               w_rd;
    logic               w_wr;
    logic               w_drop_full;
    logic               w_drop_bad;

    // Destination id lives in the top byte: {row, col}.
    assign w_dst   = din[PCKG_SZ-1 -: 8];
    assign w_row   = w_dst[7:4];
    assign w_col   = w_dst[3:0];
    assign w_legal = (w_dst == BROADCAST) ||
                     ((w_row >= 4'd1) && (w_row <= 4'd4) &&
                      (w_col >= 4'd1) && (w_col <= 4'd4));

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // A pop only counts when there is something to pop; a pop that frees a
    // slot in a full FIFO lets a same-cycle push through.
    assign w_rd        = popin & ~w_empty;
    assign w_wr        = push & w_legal & (~w_full | w_rd);
    assign w_drop_bad  = push & ~w_legal;
    assign w_drop_full = push & w_legal & w_full & ~w_rd;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Remember the last presented head so the output holds while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else if (!w_empty) begin
            r_hold <= r_mem[r_rd_ptr];
        end
    end

    // Sticky error flags and saturating drop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_drop_cnt    <= '0;
            r_bad_dst_cnt <= '0;
        end else begin
            if (w_drop_full) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != c_SAT) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
            if (popin && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_drop_bad && (r_bad_dst_cnt != c_SAT)) begin
                r_bad_dst_cnt <= r_bad_dst_cnt + 16'd1;
            end
        end
    end

    assign full          = w_full;
    assign count         = r_count;
    assign pndng_i_in    = ~w_empty;
    assign data_out_i_in = w_empty ? r_hold : r_mem[r_rd_ptr];
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;
    assign drop_cnt      = r_drop_cnt;
    assign bad_dst_cnt   = r_bad_dst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mesh_term_src_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesh_term_src_fifo
// Brief    : Scoreboard bench for mesh_term_src_fifo: directed scenarios then
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesh_term_src_fifo;

    localparam int PCKG_SZ    = 40;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               push = 1'b0;
    logic [PCKG_SZ-1:0] din = '0;
    logic               full;
    logic [2:0]         count;
    logic               pndng_i_in;
    logic [PCKG_SZ-1:0] data_out_i_in;
    logic               popin = 1'b0;
    logic               overflow;
    logic               underflow;
    logic [15:0]        drop_cnt;
    logic [15:0]        bad_dst_cnt;

    mesh_term_src_fifo #(
        .PCKG_SZ    (PCKG_SZ),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BROADCAST  (8'hFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .din           (din),
        .full          (full),
        .count         (count),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .popin         (popin),
        .overflow      (overflow),
        .underflow     (underflow),
        .drop_cnt      (drop_cnt),
        .bad_dst_cnt   (bad_dst_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [PCKG_SZ-1:0] sb_q[$];
    int                 m_count = 0;
    bit                 m_ovf   = 0;
    bit                 m_unf   = 0;
    int                 m_drop  = 0;
    int                 m_bad   = 0;
    logic [PCKG_SZ-1:0] m_last  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit legal(input logic [7:0] dst);
        logic [3:0] r;
        logic [3:0] c;
        r = dst[7:4];
        c = dst[3:0];
        return (dst == 8'hFF) || (r >= 1 && r <= 4 && c >= 1 && c <= 4);
    endfunction

    function automatic logic [PCKG_SZ-1:0] pkt(input logic [7:0] dst, input logic [31:0] pay);
        return {dst, pay};
    endfunction

    // One clock of stimulus: update the model from pre-edge state, then check.
    task automatic step(input bit p, input logic [PCKG_SZ-1:0] d, input bit pi, input bit r);
        bit pop_ok;
        push  = p;
        din   = d;
        popin = pi;
        reset = r;
        if (r) begin
            sb_q.delete();
            m_count = 0; m_ovf = 0; m_unf = 0; m_drop = 0; m_bad = 0; m_last = '0;
        end else begin
            pop_ok = pi && (m_count > 0);
            if (pi && m_count == 0) m_unf = 1;
            if (pop_ok && sb_q.size() > 0) m_last = sb_q[0];
            if (p) begin
                if (!legal(d[PCKG_SZ-1 -: 8])) begin
                    if (m_bad < 65535) m_bad++;
                end else if (m_count < FIFO_DEPTH || pop_ok) begin
                    sb_q.push_back(d);
                    if (!pop_ok) m_count++;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                if (pop_ok && !(legal(d[PCKG_SZ-1 -: 8]))) m_count--;
            end else if (pop_ok) begin
                m_count--;
            end
        end
        @(posedge clk);
        #1;
        chk("count",       64'(count),       64'(m_count));
        chk("full",        64'(full),        64'(m_count == FIFO_DEPTH));
        chk("pndng",       64'(pndng_i_in),  64'(m_count != 0));
        chk("overflow",    64'(overflow),    64'(m_ovf));
        chk("underflow",   64'(underflow),   64'(m_unf));
        chk("drop_cnt",    64'(drop_cnt),    64'(m_drop));
        chk("bad_dst_cnt", 64'(bad_dst_cnt), 64'(m_bad));
        if (m_count == 0) chk("held_data", 64'(data_out_i_in), 64'(m_last));
    endtask

    // Monitor: every cycle the mesh consumes the head, compare with the scoreboard.
    always @(negedge clk) begin
        if (!reset && popin && pndng_i_in) begin
            if (sb_q.size() == 0) begin
                chk("pop_unexpected", 64'(data_out_i_in), 64'hDEAD);
            end else begin
                chk("pop_data", 64'(data_out_i_in), 64'(sb_q.pop_front()));
            end
        end
    end

    function automatic logic [7:0] rand_dst();
        case ($urandom_range(0, 9))
            0:       return 8'hFF;
            1, 2:    return {4'($urandom_range(5, 15)), 4'($urandom_range(0, 15))};
            3:       return {4'($urandom_range(1, 4)), 4'h0};
            default: return {4'($urandom_range(1, 4)), 4'($urandom_range(1, 4))};
        endcase
    endfunction

    initial begin
        // Reset then idle
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, '0, 0, 0);

        // Fill with 4 legal packets, then one overflowing push
        for (int i = 1; i <= 4; i++) step(1, pkt(8'h23, 32'(i)), 0, 0);
        step(1, pkt(8'h23, 32'd5), 0, 0);

        // Drain in order; output must then hold the last payload
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Illegal destinations then broadcast
        step(1, pkt(8'h05, 32'hA1), 0, 0);
        step(1, pkt(8'h50, 32'hA2), 0, 0);
        step(1, pkt(8'hFF, 32'hA3), 0, 0);
        step(0, '0, 1, 0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1, pkt(8'h44, 32'h100 + 32'(i)), 0, 0);
        step(1, pkt(8'h11, 32'h1FF), 1, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

        // Pop while empty
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Reset with 3 packets buffered
        for (int i = 0; i < 3; i++) step(1, pkt(8'h32, 32'h200 + 32'(i)), 0, 0);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);

        // Round trip of 6 packets crossing the pointer wrap
        for (int i = 0; i < 3; i++) step(1, pkt(8'h14, 32'h300 + 32'(i)), 0, 0);
        for (int i = 3; i < 6; i++) step(1, pkt(8'h41, 32'h300 + 32'(i)), 1, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 6,
                 pkt(rand_dst(), $urandom()),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 149) == 0);
        end

        // Drain and confirm the scoreboard has been fully consumed
        for (int i = 0; i < FIFO_DEPTH + 1; i++) step(0, '0, 1, 0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
